// File: rtl/alu_scheduler_pkg.sv
// Shared types for the ALU scheduler: the ALU opcode set, the scheduler FSM
// states and the requester-count ceiling.
package alu_scheduler_pkg;

    localparam int ALU_OP_W          = 4;
    localparam int ALU_SCHED_MAX_REQ = 8;

    // ALU operations understood by the shared ALU. Any other encoding is
    // reported back by the ALU with alu_valid = 0.
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLTS = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_ADDR = 4'd9
    } alu_opcode_e;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_EXEC = 2'd1,
        SCHED_RESP = 2'd2
    } alu_sched_state_e;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Combinational requester arbiter for the ALU scheduler.
// Default: round-robin, search starts one past last_grant and wraps.
// With ALU_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// and the last_grant input does not exist.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
`ifndef ALU_SCHED_FIXED_PRIO_EN
    input  logic [IDX_W-1:0]   last_grant,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand_idx;
`ifndef ALU_SCHED_FIXED_PRIO_EN
    int               cand;
`endif

    // Pick the first asserted request in search order.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves a value unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand_idx  = '0;
`ifdef ALU_SCHED_FIXED_PRIO_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = IDX_W'(k);
            if (!found && req[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
`else
        cand = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
`endif
        if (found) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU among NUM_REQ requesters.
// IDLE accepts one request (arbitrated), EXEC drives the ALU for a cycle and
// registers its result, RESP holds the response until the granted requester
// takes it. Optional macro ALU_SCHED_FIXED_PRIO_EN selects fixed-priority
// arbitration instead of round-robin; FSM and timing are unchanged.
module alu_scheduler
    import alu_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid_ip,
    output logic [NUM_REQ-1:0]       req_ready_op,
    input  alu_opcode_e              req_operator_ip [NUM_REQ],
    input  logic [NUM_REQ-1:0][31:0] req_operand_a_ip,
    input  logic [NUM_REQ-1:0][31:0] req_operand_b_ip,
    output logic [NUM_REQ-1:0]       rsp_valid_op,
    input  logic [NUM_REQ-1:0]       rsp_ready_ip,
    output logic [31:0]              rsp_result_op,
    output logic                     rsp_error_op,
    output logic                     alu_enable_op,
    output alu_opcode_e              alu_operator_op,
    output logic [31:0]              alu_operand_a_op,
    output logic [31:0]              alu_operand_b_op,
    input  logic [31:0]              alu_result_ip,
    input  logic                     alu_valid_ip
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam alu_opcode_e OP_ZERO = alu_opcode_e'({ALU_OP_W{1'b0}});

    alu_sched_state_e state_q, state_d;
    alu_opcode_e      op_q, op_d;
    logic [31:0]      operand_a_q, operand_a_d;
    logic [31:0]      operand_b_q, operand_b_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [31:0]      result_q, result_d;
    logic             error_q, error_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
`endif

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;

    alu_rr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .IDX_W      (IDX_W)
    ) u_arbiter (
        .req        (req_valid_ip),
`ifndef ALU_SCHED_FIXED_PRIO_EN
        .last_grant (last_grant_q),
`endif
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    // Next-state logic and state-decoded outputs of the scheduler FSM.
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        operand_a_d      = operand_a_q;
        operand_b_d      = operand_b_q;
        grant_idx_d      = grant_idx_q;
        result_d         = result_q;
        error_d          = error_q;
`ifndef ALU_SCHED_FIXED_PRIO_EN
        last_grant_d     = last_grant_q;
`endif
        req_ready_op     = '0;
        rsp_valid_op     = '0;
        alu_enable_op    = 1'b0;
        alu_operator_op  = OP_ZERO;
        alu_operand_a_op = '0;
        alu_operand_b_op = '0;

        unique case (state_q)
            SCHED_IDLE: begin
                if (|req_valid_ip) begin
                    req_ready_op = arb_grant;
                    op_d         = req_operator_ip[arb_idx];
                    operand_a_d  = req_operand_a_ip[arb_idx];
                    operand_b_d  = req_operand_b_ip[arb_idx];
                    grant_idx_d  = arb_idx;
`ifndef ALU_SCHED_FIXED_PRIO_EN
                    last_grant_d = arb_idx;
`endif
                    state_d      = SCHED_EXEC;
                end
            end
            SCHED_EXEC: begin
                alu_enable_op    = 1'b1;
                alu_operator_op  = op_q;
                alu_operand_a_op = operand_a_q;
                alu_operand_b_op = operand_b_q;
                // Unsupported opcodes return a clean zero plus the error flag.
                result_d         = alu_valid_ip ? alu_result_ip : 32'd0;
                error_d          = ~alu_valid_ip;
                state_d          = SCHED_RESP;
            end
            SCHED_RESP: begin
                rsp_valid_op[grant_idx_q] = 1'b1;
                if (rsp_ready_ip[grant_idx_q]) state_d = SCHED_IDLE;
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    // State register; reset drops any pending response and clears the latched operands.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge value of the others, independent of statement order.
        if (reset) begin
            state_q      <= SCHED_IDLE;
            op_q         <= OP_ZERO;
            operand_a_q  <= '0;
            operand_b_q  <= '0;
            grant_idx_q  <= '0;
            result_q     <= '0;
            error_q      <= 1'b0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            last_grant_q <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            operand_a_q  <= operand_a_d;
            operand_b_q  <= operand_b_d;
            grant_idx_q  <= grant_idx_d;
            result_q     <= result_d;
            error_q      <= error_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign rsp_result_op = result_q;
    assign rsp_error_op  = error_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler with three requesters. A behavioural
// ALU answers the DUT's ALU port; a reference model of the arbitration rule
// and transaction timing predicts every observed value.
module tb_alu_scheduler;
    import alu_scheduler_pkg::*;

    localparam int N = 3;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid_ip;
    logic [N-1:0]      req_ready_op;
    alu_opcode_e       req_operator_ip [N];
    logic [N-1:0][31:0] req_operand_a_ip;
    logic [N-1:0][31:0] req_operand_b_ip;
    logic [N-1:0]      rsp_valid_op;
    logic [N-1:0]      rsp_ready_ip;
    logic [31:0]       rsp_result_op;
    logic              rsp_error_op;
    logic              alu_enable_op;
    alu_opcode_e       alu_operator_op;
    logic [31:0]       alu_operand_a_op;
    logic [31:0]       alu_operand_b_op;
    logic [31:0]       alu_result_ip;
    logic              alu_valid_ip;

    int n_checks = 0;
    int n_fail   = 0;
    int last_win = N - 1;

    alu_opcode_e op_r [N];
    logic [31:0] a_r  [N];
    logic [31:0] b_r  [N];
    alu_opcode_e op_tab [11];
    int          w;

    alu_scheduler #(.NUM_REQ(N)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_ip     (req_valid_ip),
        .req_ready_op     (req_ready_op),
        .req_operator_ip  (req_operator_ip),
        .req_operand_a_ip (req_operand_a_ip),
        .req_operand_b_ip (req_operand_b_ip),
        .rsp_valid_op     (rsp_valid_op),
        .rsp_ready_ip     (rsp_ready_ip),
        .rsp_result_op    (rsp_result_op),
        .rsp_error_op     (rsp_error_op),
        .alu_enable_op    (alu_enable_op),
        .alu_operator_op  (alu_operator_op),
        .alu_operand_a_op (alu_operand_a_op),
        .alu_operand_b_op (alu_operand_b_op),
        .alu_result_ip    (alu_result_ip),
        .alu_valid_ip     (alu_valid_ip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: {valid, result}. The address-generation op scales the
    // index operand by two.
    function automatic logic [32:0] alu_ref(alu_opcode_e op, logic [31:0] a, logic [31:0] b);
        case (op)
            ALU_ADD:  return {1'b1, a + b};
            ALU_SUB:  return {1'b1, a - b};
            ALU_XOR:  return {1'b1, a ^ b};
            ALU_OR:   return {1'b1, a | b};
            ALU_AND:  return {1'b1, a & b};
            ALU_SLTS: return {1'b1, 31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU: return {1'b1, 31'd0, (a < b)};
            ALU_SLL:  return {1'b1, a << b[4:0]};
            ALU_SRL:  return {1'b1, a >> b[4:0]};
            ALU_ADDR: return {1'b1, a + (b << 1)};
            default:  return {1'b0, 32'd0};
        endcase
    endfunction

    logic [32:0] alu_model;
    assign alu_model     = alu_ref(alu_operator_op, alu_operand_a_op, alu_operand_b_op);
    assign alu_valid_ip  = alu_model[32];
    // Garbage on an unsupported op so the scheduler must zero it itself.
    assign alu_result_ip = alu_model[32] ? alu_model[31:0] : 32'hDEAD_BEEF;

    // Reference arbitration: which requester should win for this mask.
    function automatic int pick(logic [N-1:0] m);
`ifdef ALU_SCHED_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (m[k]) return k;
`else
        for (int k = 1; k <= N; k++) if (m[(last_win + k) % N]) return (last_win + k) % N;
`endif
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready_op), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid_op), 64'd0);
        check({tag, "_alu_en"},    64'(alu_enable_op), 64'd0);
        check({tag, "_alu_op"},    64'(alu_operator_op), 64'd0);
        check({tag, "_alu_a"},     64'(alu_operand_a_op), 64'd0);
        check({tag, "_alu_b"},     64'(alu_operand_b_op), 64'd0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        req_valid_ip = '0;
        rsp_ready_ip = '0;
        step();
        step();
        #1;
        check_quiet("reset");
        check("reset_result", 64'(rsp_result_op), 64'd0);
        check("reset_error",  64'(rsp_error_op), 64'd0);
        reset    = 1'b0;
        last_win = N - 1;
        step();
    endtask

    // One full transaction: requests in mask stay asserted throughout; the
    // granted response is held back for `hold` cycles before being accepted.
    task automatic round(input logic [N-1:0] mask, input int hold, output int win);
        logic [32:0]  r;
        logic [31:0]  exp_res;
        logic         exp_err;
        logic [N-1:0] onehot;
        logic [N-1:0] noise;
        req_valid_ip = mask;
        rsp_ready_ip = '0;
        for (int i = 0; i < N; i++) begin
            req_operator_ip[i]  = op_r[i];
            req_operand_a_ip[i] = a_r[i];
            req_operand_b_ip[i] = b_r[i];
        end
        #1;
        win = pick(mask);
        if (win < 0) begin
            check_quiet("idle");
            step();
            return;
        end
        onehot      = '0;
        onehot[win] = 1'b1;
        // Cycle T: combinational grant, ALU untouched.
        check("grant",          64'(req_ready_op), 64'(onehot));
        check("accept_alu_en",  64'(alu_enable_op), 64'd0);
        check("accept_rsp",     64'(rsp_valid_op), 64'd0);
        step();
        last_win = win;
        // Cycle T+1: ALU driven from the captured request.
        check("exec_ready",  64'(req_ready_op), 64'd0);
        check("exec_rsp",    64'(rsp_valid_op), 64'd0);
        check("exec_alu_en", 64'(alu_enable_op), 64'd1);
        check("exec_alu_op", 64'(alu_operator_op), 64'(op_r[win]));
        check("exec_alu_a",  64'(alu_operand_a_op), 64'(a_r[win]));
        check("exec_alu_b",  64'(alu_operand_b_op), 64'(b_r[win]));
        r       = alu_ref(op_r[win], a_r[win], b_r[win]);
        exp_res = r[32] ? r[31:0] : 32'd0;
        exp_err = ~r[32];
        step();
        // Cycle T+2 onward: response held until the owner accepts it.
        for (int h = 0; h <= hold; h++) begin
            noise = N'($urandom);
            rsp_ready_ip = (h == hold) ? (noise | onehot) : (noise & ~onehot);
            #1;
            check("rsp_valid",  64'(rsp_valid_op), 64'(onehot));
            check("rsp_result", 64'(rsp_result_op), 64'(exp_res));
            check("rsp_error",  64'(rsp_error_op), 64'(exp_err));
            check("rsp_ready",  64'(req_ready_op), 64'd0);
            check("rsp_alu_en", 64'(alu_enable_op), 64'd0);
            check("rsp_alu_a",  64'(alu_operand_a_op), 64'd0);
            step();
        end
        rsp_ready_ip = '0;
    endtask

    task automatic set_all(input alu_opcode_e op, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < N; i++) begin
            op_r[i] = op;
            a_r[i]  = a;
            b_r[i]  = b;
        end
    endtask

    initial begin
        op_tab = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLTS,
                   ALU_SLTU, ALU_SLL, ALU_SRL, ALU_ADDR, alu_opcode_e'(4'hF)};
        reset        = 1'b1;
        req_valid_ip = '0;
        rsp_ready_ip = '0;
        for (int i = 0; i < N; i++) begin
            req_operator_ip[i]  = ALU_ADD;
            req_operand_a_ip[i] = '0;
            req_operand_b_ip[i] = '0;
        end
        set_all(ALU_ADD, 32'd0, 32'd0);
        @(negedge clk);
        do_reset();

        // Single ADD from requester 0.
        set_all(ALU_ADD, 32'd5, 32'd7);
        round(3'b001, 0, w);

        // Requesters 0 and 1 both hold SUB continuously, immediate rsp_ready.
        do_reset();
        set_all(ALU_SUB, 32'd100, 32'd1);
        a_r[1] = 32'd3;
        for (int k = 0; k < 4; k++) round(3'b011, 0, w);

        // SLTS with response back-pressure while requester 0 keeps asking.
        set_all(ALU_SLTS, 32'd5, 32'd7);
        round(3'b001, 0, w);
        round(3'b011, 4, w);

        // Unsupported opcode.
        set_all(alu_opcode_e'(4'hF), 32'h1234, 32'h5678);
        round(3'b001, 1, w);

        // Reset while in EXEC: no response afterwards, requester 0 wins next.
        set_all(ALU_ADD, 32'd40, 32'd2);
        req_valid_ip = 3'b011;
        for (int i = 0; i < N; i++) begin
            req_operator_ip[i]  = op_r[i];
            req_operand_a_ip[i] = a_r[i];
            req_operand_b_ip[i] = b_r[i];
        end
        step();
        reset        = 1'b1;
        req_valid_ip = '0;
        step();
        #1;
        check_quiet("mid_reset");
        check("mid_reset_result", 64'(rsp_result_op), 64'd0);
        check("mid_reset_error",  64'(rsp_error_op), 64'd0);
        reset    = 1'b0;
        last_win = N - 1;
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            check("post_reset_rsp", 64'(rsp_valid_op), 64'd0);
        end
        step();
        round(3'b111, 0, w);

        // Only requester 2 valid: second grant must wrap around to it.
        set_all(ALU_ADD, 32'd1, 32'd1);
        round(3'b100, 0, w);
        set_all(ALU_ADDR, 32'h100, 32'd4);
        round(3'b100, 2, w);

        // Randomized traffic.
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < N; i++) begin
                op_r[i] = op_tab[$urandom_range(0, 10)];
                a_r[i]  = $urandom;
                b_r[i]  = (($urandom_range(0, 3)) == 0) ? a_r[i] : $urandom;
            end
            round(N'($urandom_range(0, 7)), int'($urandom_range(0, 3)), w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
